// File: rtl/ipf_pkg.sv
// Shared definitions for the IPF front end: feeder FSM states, frame
// geometry, parameter-word field positions and filter type codes.
package ipf_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PAR_REQ  = 3'd1,
        S_PAR_WAIT = 3'd2,
        S_STREAM   = 3'd3,
        S_DONE     = 3'd4
    } ipf_state_e;

    localparam int FRAME_W  = 128;
    localparam int FRAME_SH = $clog2(FRAME_W);

    // Parameter word layout: {type, band_pos, wo_class, offset}
    localparam int PF_TYPE_HI = 23;
    localparam int PF_TYPE_LO = 22;
    localparam int PF_BAND_HI = 21;
    localparam int PF_BAND_LO = 17;
    localparam int PF_WO      = 16;
    localparam int PF_OFF_HI  = 15;
    localparam int PF_OFF_LO  = 0;

    localparam logic [1:0] IPF_OFF = 2'd0;
    localparam logic [1:0] IPF_PO  = 2'd1;
    localparam logic [1:0] IPF_WO  = 2'd2;

    // Number of LCUs along one frame edge for a given size code.
    function automatic logic [3:0] lcus_per_row(input logic [1:0] size);
        return 4'd8 >> size;
    endfunction

endpackage

// File: rtl/ipf_pix_fifo.sv
// Two-entry 8-bit pixel FIFO between the image ROM and the IPF input.
module ipf_pix_fifo (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] data_i,
    input  logic       pop_i,
    output logic [7:0] head_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    logic [7:0] mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;

    // Storage, pointers and occupancy; everything clears on reset so the
    // head reads as zero until the first pixel arrives.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/ipf_lcu_feeder.sv
// Walks the frame in LCU order, fetches per-LCU filter parameters and
// streams the LCU's pixels to the IPF under busy backpressure.
module ipf_lcu_feeder
    import ipf_pkg::*;
#(
    parameter int IMG_AW = 14,
    parameter int PAR_AW = 6,
    parameter int PAR_DW = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        lcu_size_in,
    output logic              img_rd,
    output logic [IMG_AW-1:0] img_addr,
    input  logic [7:0]        img_q,
    output logic              par_rd,
    output logic [PAR_AW-1:0] par_addr,
    input  logic [PAR_DW-1:0] par_q,
    input  logic              busy,
    output logic              in_en,
    output logic [7:0]        din,
    output logic [1:0]        ipf_type,
    output logic [4:0]        ipf_band_pos,
    output logic              ipf_wo_class,
    output logic [15:0]       ipf_offset,
    output logic [2:0]        lcu_x,
    output logic [2:0]        lcu_y,
    output logic [1:0]        lcu_size,
    output logic              done
);

    ipf_state_e  state_q, state_d;
    logic [1:0]  size_q, size_d;
    logic [2:0]  x_q, x_d, y_q, y_d;
    logic [6:0]  r_q, r_d, c_q, c_d;
    logic        issued_all_q, issued_all_d;
    logic [14:0] pop_cnt_q, pop_cnt_d;
    logic        inflight_q;
    logic        done_q, done_d;
    logic [1:0]  type_q, type_d;
    logic [4:0]  band_q, band_d;
    logic        wo_q, wo_d;
    logic [15:0] off_q, off_d;

    logic        start_acc, par_live, rd_window, stream_st;
    logic        fifo_empty;
    logic [1:0]  fifo_cnt;
    logic [7:0]  fifo_head;
    logic        last_pop, frame_end, rd_go;
    logic [2:0]  lcu_max;
    logic [6:0]  n_m1;
    logic [14:0] npix_m1;
    logic [2:0]  occ_after;
    logic [IMG_AW-1:0] row_idx, pix_addr;
    logic [PAR_AW-1:0] par_idx;

    ipf_pix_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (inflight_q),
        .data_i  (img_q),
        .pop_i   (in_en),
        .head_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    // LCU geometry derived from the latched size code.
    assign lcu_max = 3'(lcus_per_row(size_q) - 4'd1);
    assign n_m1    = 7'((8'd16 << size_q) - 8'd1);
    assign npix_m1 = 15'((16'd256 << {size_q, 1'b0}) - 16'd1);

    // Frame address of the next pixel, shifts and adds only.
    assign row_idx  = (IMG_AW'(y_q) << (4 + size_q)) + IMG_AW'(r_q);
    assign pix_addr = (row_idx << FRAME_SH) + (IMG_AW'(x_q) << (4 + size_q)) + IMG_AW'(c_q);
    assign par_idx  = (PAR_AW'(y_q) << (3 - size_q)) + PAR_AW'(x_q);

    // Pixels leave only while streaming and the IPF is ready.
    assign in_en     = stream_st & ~fifo_empty & ~busy;
    assign last_pop  = in_en & (pop_cnt_q == npix_m1);
    assign frame_end = last_pop & (x_q == lcu_max) & (y_q == lcu_max);

    // Credit check counts the pop happening this cycle so a full-rate
    // stream keeps one pixel buffered and one in flight.
    assign occ_after = {1'b0, fifo_cnt} + {2'b00, inflight_q} - {2'b00, in_en};
    assign rd_go     = rd_window & ~issued_all_q & (occ_after < 3'd2);

    assign img_rd   = rd_go;
    assign img_addr = rd_go ? pix_addr : '0;
    assign par_addr = par_rd ? par_idx : '0;
    assign din      = fifo_head;

    // Parameter ROM data is forwarded straight through while it is being
    // registered so the outputs are valid in the PAR_WAIT cycle itself.
    assign ipf_type     = par_live ? par_q[PF_TYPE_HI:PF_TYPE_LO] : type_q;
    assign ipf_band_pos = par_live ? par_q[PF_BAND_HI:PF_BAND_LO] : band_q;
    assign ipf_wo_class = par_live ? par_q[PF_WO]                 : wo_q;
    assign ipf_offset   = par_live ? par_q[PF_OFF_HI:PF_OFF_LO]   : off_q;
    assign lcu_x        = x_q;
    assign lcu_y        = y_q;
    assign lcu_size     = size_q;
    assign done         = done_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and phase decodes.
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        par_rd    = 1'b0;
        par_live  = 1'b0;
        rd_window = 1'b0;
        stream_st = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = S_PAR_REQ;
                end
            end
            S_PAR_REQ: begin
                par_rd  = 1'b1;
                state_d = S_PAR_WAIT;
            end
            S_PAR_WAIT: begin
                par_live  = 1'b1;
                rd_window = 1'b1;
                state_d   = S_STREAM;
            end
            S_STREAM: begin
                rd_window = 1'b1;
                stream_st = 1'b1;
                if (last_pop) begin
                    state_d = frame_end ? S_DONE : S_PAR_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Counter, position and parameter next-state logic.
    always_comb begin
        size_d       = size_q;
        x_d          = x_q;
        y_d          = y_q;
        r_d          = r_q;
        c_d          = c_q;
        issued_all_d = issued_all_q;
        pop_cnt_d    = pop_cnt_q;
        done_d       = done_q;
        type_d       = type_q;
        band_d       = band_q;
        wo_d         = wo_q;
        off_d        = off_q;

        if (start_acc) begin
            size_d       = lcu_size_in;
            x_d          = '0;
            y_d          = '0;
            r_d          = '0;
            c_d          = '0;
            issued_all_d = 1'b0;
            pop_cnt_d    = '0;
            done_d       = 1'b0;
        end

        if (par_live) begin
            type_d = par_q[PF_TYPE_HI:PF_TYPE_LO];
            band_d = par_q[PF_BAND_HI:PF_BAND_LO];
            wo_d   = par_q[PF_WO];
            off_d  = par_q[PF_OFF_HI:PF_OFF_LO];
        end

        if (rd_go) begin
            if (c_q == n_m1) begin
                c_d = '0;
                if (r_q == n_m1) begin
                    issued_all_d = 1'b1;
                end else begin
                    r_d = r_q + 7'd1;
                end
            end else begin
                c_d = c_q + 7'd1;
            end
        end

        if (in_en) begin
            pop_cnt_d = pop_cnt_q + 15'd1;
        end

        if (last_pop) begin
            pop_cnt_d    = '0;
            r_d          = '0;
            c_d          = '0;
            issued_all_d = 1'b0;
            if (frame_end) begin
                done_d = 1'b1;
            end else if (x_q == lcu_max) begin
                x_d = '0;
                y_d = y_q + 3'd1;
            end else begin
                x_d = x_q + 3'd1;
            end
        end
    end

    // Datapath and control registers; all outputs read zero after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            size_q       <= '0;
            x_q          <= '0;
            y_q          <= '0;
            r_q          <= '0;
            c_q          <= '0;
            issued_all_q <= 1'b0;
            pop_cnt_q    <= '0;
            inflight_q   <= 1'b0;
            done_q       <= 1'b0;
            type_q       <= '0;
            band_q       <= '0;
            wo_q         <= 1'b0;
            off_q        <= '0;
        end else begin
            size_q       <= size_d;
            x_q          <= x_d;
            y_q          <= y_d;
            r_q          <= r_d;
            c_q          <= c_d;
            issued_all_q <= issued_all_d;
            pop_cnt_q    <= pop_cnt_d;
            inflight_q   <= rd_go;
            done_q       <= done_d;
            type_q       <= type_d;
            band_q       <= band_d;
            wo_q         <= wo_d;
            off_q        <= off_d;
        end
    end

endmodule

// File: tb/tb_ipf_lcu_feeder.sv
// Self-checking bench for ipf_lcu_feeder: parameter decode table, start
// latency, full frames with scripted and random backpressure, mid-frame
// reset and ignored start pulses, against a frame-walk reference model.
module tb_ipf_lcu_feeder;
    import ipf_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  lcu_size_in = 2'd0;
    logic        img_rd;
    logic [13:0] img_addr;
    logic [7:0]  img_q = 8'd0;
    logic        par_rd;
    logic [5:0]  par_addr;
    logic [23:0] par_q = 24'd0;
    logic        busy = 1'b0;
    logic        in_en;
    logic [7:0]  din;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic        ipf_wo_class;
    logic [15:0] ipf_offset;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  lcu_size;
    logic        done;

    ipf_lcu_feeder dut (
        .clk(clk), .reset(reset), .start(start), .lcu_size_in(lcu_size_in),
        .img_rd(img_rd), .img_addr(img_addr), .img_q(img_q),
        .par_rd(par_rd), .par_addr(par_addr), .par_q(par_q),
        .busy(busy), .in_en(in_en), .din(din),
        .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos),
        .ipf_wo_class(ipf_wo_class), .ipf_offset(ipf_offset),
        .lcu_x(lcu_x), .lcu_y(lcu_y), .lcu_size(lcu_size), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    function automatic int exp_addr(input int size, input int idx);
        int n, ppl_l, lpr_l, lcu, w, lx, ly, r, c;
        n = 16 << size;
        ppl_l = n * n;
        lpr_l = FRAME_W / n;
        lcu = idx / ppl_l;
        w = idx % ppl_l;
        ly = lcu / lpr_l;
        lx = lcu % lpr_l;
        r = w / n;
        c = w % n;
        return (ly * n + r) * FRAME_W + lx * n + c;
    endfunction

    function automatic logic [7:0] pix_of(input int a);
        logic [13:0] v;
        v = 14'(a);
        return v[7:0] ^ {v[13:8], 2'b01};
    endfunction

    function automatic logic [23:0] par_word(input int a);
        logic [5:0] v;
        v = 6'(a);
        return {v, ~v, v ^ 6'h2A, v + 6'd5};
    endfunction

    // ---------------- ROM models ----------------
    logic        use_ovr = 1'b0;
    logic [23:0] par_ovr = 24'd0;

    always @(posedge clk) begin
        if (img_rd) img_q <= pix_of(int'(img_addr));
        else        img_q <= 8'h5A;
        if (par_rd) par_q <= use_ovr ? par_ovr : par_word(int'(par_addr));
        else        par_q <= 24'h0;
    end

    // ---------------- stream monitor ----------------
    logic [1:0] m_size = 2'd0;
    int  total = 16384, ppl = 256, lpr = 8;
    bit  mon_on = 1'b0, mon_prev = 1'b0, pat_mode = 1'b0;
    int  rd_idx, acc_idx, addr_err, din_err, par_err, busy_err, done_err, max_out, stall_reqs;

    always @(negedge clk) begin
        int ea, lcu, outst;
        #1;
        if (mon_on && !mon_prev) begin
            rd_idx = 0; acc_idx = 0; addr_err = 0; din_err = 0; par_err = 0;
            busy_err = 0; done_err = 0; max_out = 0; stall_reqs = 0;
        end
        mon_prev = mon_on;
        if (mon_on) begin
            if (img_rd) begin
                if (rd_idx >= total || int'(img_addr) != exp_addr(int'(m_size), rd_idx)) addr_err++;
                rd_idx++;
            end
            if (in_en) begin
                if (busy) busy_err++;
                if (acc_idx < total) begin
                    ea = exp_addr(int'(m_size), acc_idx);
                    if (din !== pix_of(ea)) din_err++;
                    lcu = acc_idx / ppl;
                    if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} !== par_word(lcu)) par_err++;
                    if (lcu_x !== 3'(lcu % lpr) || lcu_y !== 3'(lcu / lpr) || lcu_size !== m_size) par_err++;
                end else begin
                    din_err++;
                end
                acc_idx++;
                if (pat_mode && (acc_idx % 16 == 0) && acc_idx <= 1024) stall_reqs++;
            end
            if (done && acc_idx < total) done_err++;
            outst = rd_idx - acc_idx;
            if (outst > max_out) max_out = outst;
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b0; start = 1'b0; busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [63:0] all_outs();
        return {img_rd, img_addr, par_rd, par_addr, in_en, din, ipf_type, ipf_band_pos,
                ipf_wo_class, ipf_offset, lcu_x, lcu_y, lcu_size, done};
    endfunction

    // Run one whole frame; bmode 0 = never busy, 1 = 64-cycle stall after
    // every 16th pixel (first 1024 pixels), 2 = random busy.
    task automatic run_frame(input logic [1:0] size, input int bmode, input bit noise, input bit lat);
        int k, stall_left, stall_seen;
        m_size = size;
        ppl = (16 << size) * (16 << size);
        lpr = 8 >> size;
        total = 16384;
        use_ovr = 1'b0;
        pat_mode = (bmode == 1);
        @(negedge clk);
        start = 1'b1; lcu_size_in = size; busy = 1'b0;
        @(negedge clk);
        start = 1'b0; lcu_size_in = ~size; mon_on = 1'b1;
        k = 1; stall_left = 0; stall_seen = 0;
        while (k < 40000) begin
            #2;
            if (lat) begin
                if (k == 1) begin chk("lat par_rd T+1", par_rd, 1); chk("lat par_addr", par_addr, 0); chk("lat img_rd T+1", img_rd, 0); end
                if (k == 2) begin chk("lat img_rd T+2", img_rd, 1); chk("lat img_addr", img_addr, 0); end
                if (k == 3) chk("lat in_en T+3", in_en, 0);
                if (k == 4) begin chk("lat in_en T+4", in_en, 1); chk("lat first din", din, pix_of(0)); end
            end
            if (done) break;
            @(negedge clk);
            k++;
            if (bmode == 1) begin
                if (stall_reqs > stall_seen) begin stall_seen = stall_reqs; stall_left = 64; end
                busy = (stall_left > 0);
                if (stall_left > 0) stall_left--;
            end else if (bmode == 2) begin
                busy = ($urandom_range(0, 7) == 0);
            end else begin
                busy = 1'b0;
            end
            start = (noise && acc_idx > 0) ? ($urandom_range(0, 63) == 0) : 1'b0;
        end
        busy = 1'b0; start = 1'b0;
        chk("frame done", done, 1);
        chk("pixels accepted", acc_idx, total);
        chk("reads issued", rd_idx, total);
        chk("read addr errors", addr_err, 0);
        chk("din errors", din_err, 0);
        chk("param/pos errors", par_err, 0);
        chk("in_en with busy", busy_err, 0);
        chk("early done", done_err, 0);
        chk("max outstanding", max_out, 2);
        repeat (5) @(negedge clk);
        #2;
        chk("quiet after done", acc_idx + rd_idx, 2 * total);
        chk("done held", done, 1);
        mon_on = 1'b0;
    endtask

    typedef struct packed {
        logic [23:0] word;
        logic [1:0]  t;
        logic [4:0]  band;
        logic        wo;
        logic [15:0] off;
    } pvec_t;

    pvec_t tbl [6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, k, stab;
        tbl[0] = '{24'hA51234, IPF_WO,  5'd18, 1'b1, 16'h1234};
        tbl[1] = '{24'h000000, IPF_OFF, 5'd0,  1'b0, 16'h0000};
        tbl[2] = '{24'hFFFFFF, 2'd3,    5'd31, 1'b1, 16'hFFFF};
        tbl[3] = '{24'h42ABCD, IPF_PO,  5'd1,  1'b0, 16'hABCD};
        tbl[4] = '{24'h3E0001, IPF_OFF, 5'd31, 1'b0, 16'h0001};
        tbl[5] = '{24'h81FFFE, IPF_WO,  5'd0,  1'b1, 16'hFFFE};

        // Reset state
        repeat (3) @(negedge clk);
        #2;
        chk("outputs in reset", all_outs(), 64'd0);
        reset = 1'b1;
        @(negedge clk); #2;
        chk("outputs idle", all_outs(), 64'd0);

        // Parameter decode table, size 3 (single LCU)
        for (int i = 0; i < 6; i++) begin
            reset_dut();
            use_ovr = 1'b1; par_ovr = tbl[i].word;
            @(negedge clk); start = 1'b1; lcu_size_in = 2'd3;
            @(negedge clk); start = 1'b0;
            @(negedge clk); #2;
            chk("tbl ipf_type", ipf_type, tbl[i].t);
            chk("tbl band_pos", ipf_band_pos, tbl[i].band);
            chk("tbl wo_class", ipf_wo_class, tbl[i].wo);
            chk("tbl offset", ipf_offset, tbl[i].off);
            stab = 0;
            repeat (200) begin
                @(negedge clk); #2;
                if ({ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset} !== {tbl[i].t, tbl[i].band, tbl[i].wo, tbl[i].off}) stab++;
                if (lcu_x !== 3'd0 || lcu_y !== 3'd0 || lcu_size !== 2'd3) stab++;
            end
            chk("tbl params stable", stab, 0);
        end

        // Reset in the middle of a frame, then restart
        reset_dut();
        use_ovr = 1'b0;
        @(negedge clk); start = 1'b1; lcu_size_in = 2'd1;
        @(negedge clk); start = 1'b0;
        cnt = 0; k = 0;
        while (cnt < 300 && k < 2000) begin
            #2;
            if (in_en) cnt++;
            @(negedge clk);
            k++;
        end
        chk("reached pixel 300", cnt, 300);
        reset = 1'b0;
        @(negedge clk); #2;
        chk("outputs after mid reset", all_outs(), 64'd0);
        reset = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk); #2;
            if (in_en || img_rd || par_rd) cnt++;
        end
        chk("quiet after mid reset", cnt, 0);
        @(negedge clk); start = 1'b1; lcu_size_in = 2'd0;
        @(negedge clk); start = 1'b0; #2;
        chk("restart par_rd", par_rd, 1);
        chk("restart par_addr", par_addr, 0);
        @(negedge clk); #2;
        chk("restart img_rd", img_rd, 1);
        chk("restart img_addr", img_addr, 0);

        // Size 0 frame: start latency, scripted stalls then full rate
        reset_dut();
        repeat (5) @(negedge clk);
        run_frame(2'd0, 1, 1'b0, 1'b1);

        // Random backpressure with stray start pulses, restarted from DONE
        run_frame(2'd1, 2, 1'b1, 1'b0);
        run_frame(2'd2, 2, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
